return_addr_stack: RTL and testbench
====================================

# return_addr_stack

- Parametrised return address stack (RAS) for the LEN5 fetch-stage branch predictor. It generalises the fixed-depth RAS to configurable depth and address width, adds a selectable full-stack policy, and adds a single-level checkpoint/restore for misprediction recovery.
- The BPU pushes on calls and pops on returns. The predicted return target is read combinationally from the top of stack.
- The frontend takes a checkpoint when a branch is predicted and restores it when that branch resolves as mispredicted.

## Interface
Parameters:
- XLEN, 64: return address width in bits.
- DEPTH, 8: number of entries. Must be a power of 2 and at least 2. Default equals the global RAS_DEPTH.
- OVERWRITE_EN, 1: policy for a push when full. 1 overwrites the oldest entry (circular). 0 drops the push.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- flush_i  in  1  empty the stack and invalidate the checkpoint.
- push_i  in  1  push push_addr_i (call).
- push_addr_i  in  XLEN  return address to push.
- pop_i  in  1  pop the top entry (return).
- ckpt_i  in  1  save the current stack state.
- restore_i  in  1  restore the saved stack state.
- top_valid_o  out  1  stack is not empty.
- top_addr_o  out  XLEN  current top entry; 0 when empty.
- count_o  out  $clog2(DEPTH+1)  number of valid entries.
- ovf_o  out  1  registered one-cycle pulse: a push occurred while full.
- udf_o  out  1  registered one-cycle pulse: a pop occurred while empty.

## Operation
State:
- mem[DEPTH] of XLEN bits.
- tos: log2(DEPTH)-bit top index; wraps modulo DEPTH.
- cnt: 0..DEPTH.
- Checkpoint registers: ck_tos, ck_cnt, ck_top (XLEN), ck_valid.

Per-cycle priority is flush_i > restore_i > push/pop. Checkpoint capture runs alongside push/pop.
- flush_i: cnt=0, tos=0, ck_valid=0. All other inputs are ignored that cycle.
- restore_i with ck_valid=1: tos=ck_tos, cnt=ck_cnt, mem[ck_tos]=ck_top. push/pop/ckpt are ignored. ck_valid stays 1.
- restore_i with ck_valid=0: behaves exactly as flush_i.
- push only:
  - cnt<DEPTH: tos=tos+1, mem[tos+1]=push_addr_i, cnt+1.
  - cnt=DEPTH and OVERWRITE_EN=1: same write and pointer move, cnt stays DEPTH, ovf_o=1 next cycle.
  - cnt=DEPTH and OVERWRITE_EN=0: no state change, ovf_o=1 next cycle.
- pop only:
  - cnt>0: tos=tos-1 (wraps), cnt-1. mem is unchanged.
  - cnt=0: no state change, udf_o=1 next cycle.
- push and pop together (call that also returns):
  - cnt>0: mem[tos]=push_addr_i; tos and cnt unchanged.
  - cnt=0: behaves as push only.
- ckpt_i (without flush/restore): ck_tos=tos, ck_cnt=cnt, ck_top=mem[tos] are all sampled pre-update, i.e. the state before that cycle's push/pop. ck_valid=1.
- Outputs:
  - top_valid_o = (cnt!=0).
  - top_addr_o = cnt!=0 ? mem[tos] : 0.
  - count_o = cnt.
- Entries below the checkpointed top that were overwritten after the checkpoint are not recovered. This is an accepted approximation.

## Timing
- Reset values: tos=0, cnt=0, mem all 0, ck_* all 0, ck_valid=0.
  - Output consequences: top_valid_o=0, top_addr_o=0, count_o=0, ovf_o=0, udf_o=0.
- Reset is asynchronous and takes effect mid-operation. Any in-flight push/pop is lost.
- All state updates occur on the rising clk_i edge. top_*/count_o reflect an update in the cycle after the edge; there are no combinational paths from inputs to outputs.
- ovf_o/udf_o are asserted for exactly one cycle, the cycle after the offending request.
- No handshake is needed: every request is accepted in the cycle it is presented.

## Test plan
- Reset, then push 0x100, 0x200, 0x300 on consecutive cycles -> top_addr_o=0x300, count_o=3. Three pops -> 0x200, 0x100, then top_valid_o=0 and top_addr_o=0.
- DEPTH=4, OVERWRITE_EN=1: push 0x10,0x20,0x30,0x40,0x50 -> ovf_o pulses once after the fifth push, count_o=4. Four pops return 0x50,0x40,0x30,0x20, then empty.
- DEPTH=4, OVERWRITE_EN=0: same stimulus -> ovf_o pulses once; pops return 0x40,0x30,0x20,0x10.
- Pop on empty -> udf_o high for one cycle, count_o stays 0. Push and pop together on a stack holding 0xA -> top_addr_o=0xB (pushed value), count_o unchanged.
- Push 0xA,0xB; ckpt_i; pop; push 0xC; push 0xD; restore_i -> top_addr_o=0xB, count_o=2. Then restore_i together with flush_i -> empty, and a following restore_i also leaves the stack empty.
- Push 0x1,0x2,0x3 then assert rst_ni=0 mid-clock-cycle -> all outputs 0 immediately, without waiting for a clock edge. After release, restore_i -> stack stays empty.

Source files
------------

// File: rtl/return_addr_stack.sv
// Parametrised return address stack for the fetch-stage branch predictor.
// Holds call return addresses in a circular buffer. The top entry is read
// straight from registers, so no input reaches an output combinationally.
// A single-level checkpoint lets the frontend roll back after a mispredict.
module return_addr_stack #(
  parameter int unsigned XLEN         = 64,
  parameter int unsigned DEPTH        = 8,
  parameter bit          OVERWRITE_EN = 1'b1
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic [XLEN-1:0]            push_addr_i,
  input  logic                       pop_i,
  input  logic                       ckpt_i,
  input  logic                       restore_i,
  output logic                       top_valid_o,
  output logic [XLEN-1:0]            top_addr_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       ovf_o,
  output logic                       udf_o
);

  localparam int unsigned IW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [XLEN-1:0] mem [DEPTH];
  logic [IW-1:0]   tos;
  logic [CW-1:0]   cnt;

  logic [IW-1:0]   ck_tos;
  logic [CW-1:0]   ck_cnt;
  logic [XLEN-1:0] ck_top;
  logic            ck_valid;

  logic            ovf_q;
  logic            udf_q;

  logic            is_empty;
  logic            is_full;
  logic [IW-1:0]   tos_inc;
  logic [IW-1:0]   tos_dec;

  assign is_empty = (cnt == '0);
  assign is_full  = (cnt == FULL_CNT);
  assign tos_inc  = tos + IW'(1);
  assign tos_dec  = tos - IW'(1);

  // Stack, checkpoint and error-pulse state; flush beats restore beats push/pop.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
      tos      <= '0;
      cnt      <= '0;
      ck_tos   <= '0;
      ck_cnt   <= '0;
      ck_top   <= '0;
      ck_valid <= 1'b0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
      if (flush_i || (restore_i && !ck_valid)) begin
        // A restore with nothing saved has no sane target, so it empties the stack.
        tos      <= '0;
        cnt      <= '0;
        ck_valid <= 1'b0;
      end else if (restore_i) begin
        // Only the saved top is rewritten; deeper overwritten entries stay lost.
        tos         <= ck_tos;
        cnt         <= ck_cnt;
        mem[ck_tos] <= ck_top;
      end else begin
        if (ckpt_i) begin
          ck_tos   <= tos;
          ck_cnt   <= cnt;
          ck_top   <= mem[tos];
          ck_valid <= 1'b1;
        end
        if (push_i && pop_i && !is_empty) begin
          // Call and return in the same cycle replace the top in place.
          mem[tos] <= push_addr_i;
        end else if (push_i) begin
          if (!is_full) begin
            tos          <= tos_inc;
            mem[tos_inc] <= push_addr_i;
            cnt          <= cnt + CW'(1);
          end else begin
            ovf_q <= 1'b1;
            if (OVERWRITE_EN) begin
              tos          <= tos_inc;
              mem[tos_inc] <= push_addr_i;
            end
          end
        end else if (pop_i) begin
          if (!is_empty) begin
            tos <= tos_dec;
            cnt <= cnt - CW'(1);
          end else begin
            udf_q <= 1'b1;
          end
        end
      end
    end
  end

  assign top_valid_o = !is_empty;
  assign top_addr_o  = is_empty ? '0 : mem[tos];
  assign count_o     = cnt;
  assign ovf_o       = ovf_q;
  assign udf_o       = udf_q;

endmodule

// File: tb/tb_return_addr_stack.sv
// Directed testbench for return_addr_stack.
// One default-sized instance runs a vector table; two depth-4 instances
// (overwrite and drop policy) share the same inputs for the full-stack cases.
module tb_return_addr_stack;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        push;
  logic [63:0] push_addr;
  logic        pop;
  logic        ckpt;
  logic        restore;

  logic        valid8;
  logic [63:0] top8;
  logic [3:0]  cnt8;
  logic        ovf8;
  logic        udf8;

  logic        valid4o;
  logic [63:0] top4o;
  logic [2:0]  cnt4o;
  logic        ovf4o;
  logic        udf4o;

  logic        valid4d;
  logic [63:0] top4d;
  logic [2:0]  cnt4d;
  logic        ovf4d;
  logic        udf4d;

  int total;
  int bad;

  typedef struct {
    logic        flush;
    logic        push;
    logic        pop;
    logic        ckpt;
    logic        restore;
    logic [63:0] addr;
    logic        exp_valid;
    logic [63:0] exp_top;
    logic [3:0]  exp_cnt;
    logic        exp_ovf;
    logic        exp_udf;
  } vec_t;

  vec_t vecs[$];

  return_addr_stack #(.XLEN(64), .DEPTH(8), .OVERWRITE_EN(1'b1)) dut8 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .push_i(push),
    .push_addr_i(push_addr), .pop_i(pop), .ckpt_i(ckpt), .restore_i(restore),
    .top_valid_o(valid8), .top_addr_o(top8), .count_o(cnt8),
    .ovf_o(ovf8), .udf_o(udf8)
  );

  return_addr_stack #(.XLEN(64), .DEPTH(4), .OVERWRITE_EN(1'b1)) dut4o (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .push_i(push),
    .push_addr_i(push_addr), .pop_i(pop), .ckpt_i(ckpt), .restore_i(restore),
    .top_valid_o(valid4o), .top_addr_o(top4o), .count_o(cnt4o),
    .ovf_o(ovf4o), .udf_o(udf4o)
  );

  return_addr_stack #(.XLEN(64), .DEPTH(4), .OVERWRITE_EN(1'b0)) dut4d (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .push_i(push),
    .push_addr_i(push_addr), .pop_i(pop), .ckpt_i(ckpt), .restore_i(restore),
    .top_valid_o(valid4d), .top_addr_o(top4d), .count_o(cnt4d),
    .ovf_o(ovf4d), .udf_o(udf4d)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act,
                             input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Drives one cycle of requests, waits for the edge and samples 1 ns later.
  task automatic applyStimulus(input logic f, input logic pu, input logic po,
                               input logic ck, input logic rs,
                               input logic [63:0] a);
    flush     = f;
    push      = pu;
    pop       = po;
    ckpt      = ck;
    restore   = rs;
    push_addr = a;
    @(posedge clk);
    #1;
    flush     = 1'b0;
    push      = 1'b0;
    pop       = 1'b0;
    ckpt      = 1'b0;
    restore   = 1'b0;
    push_addr = '0;
  endtask

  task automatic check8(input string tag, input logic v, input logic [63:0] t,
                        input logic [3:0] c, input logic o, input logic u);
    checkOutput({tag, ".valid"}, {63'b0, valid8}, {63'b0, v});
    checkOutput({tag, ".top"},   top8, t);
    checkOutput({tag, ".cnt"},   {60'b0, cnt8}, {60'b0, c});
    checkOutput({tag, ".ovf"},   {63'b0, ovf8}, {63'b0, o});
    checkOutput({tag, ".udf"},   {63'b0, udf8}, {63'b0, u});
  endtask

  task automatic addVec(input logic f, input logic pu, input logic po,
                        input logic ck, input logic rs, input logic [63:0] a,
                        input logic v, input logic [63:0] t, input logic [3:0] c,
                        input logic o, input logic u);
    vec_t x;
    x.flush = f; x.push = pu; x.pop = po; x.ckpt = ck; x.restore = rs;
    x.addr = a; x.exp_valid = v; x.exp_top = t; x.exp_cnt = c;
    x.exp_ovf = o; x.exp_udf = u;
    vecs.push_back(x);
  endtask

  // Async reset pulse released well before the next rising edge.
  task automatic doReset();
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [63:0] pushes[5];
    logic [63:0] exp_o[4];
    logic [63:0] exp_d[4];
    total     = 0;
    bad       = 0;
    rst_n     = 1'b0;
    flush     = 1'b0;
    push      = 1'b0;
    pop       = 1'b0;
    ckpt      = 1'b0;
    restore   = 1'b0;
    push_addr = '0;

    //     flush push pop ckpt rest addr      valid top      cnt ovf udf
    addVec(0, 1, 0, 0, 0, 64'h100, 1, 64'h100, 1, 0, 0);
    addVec(0, 1, 0, 0, 0, 64'h200, 1, 64'h200, 2, 0, 0);
    addVec(0, 1, 0, 0, 0, 64'h300, 1, 64'h300, 3, 0, 0);
    addVec(0, 0, 1, 0, 0, 64'h0,   1, 64'h200, 2, 0, 0);
    addVec(0, 0, 1, 0, 0, 64'h0,   1, 64'h100, 1, 0, 0);
    addVec(0, 0, 1, 0, 0, 64'h0,   0, 64'h0,   0, 0, 0);
    addVec(0, 0, 1, 0, 0, 64'h0,   0, 64'h0,   0, 0, 1);
    addVec(0, 0, 0, 0, 0, 64'h0,   0, 64'h0,   0, 0, 0);
    addVec(0, 1, 0, 0, 0, 64'hA,   1, 64'hA,   1, 0, 0);
    addVec(0, 1, 1, 0, 0, 64'hB,   1, 64'hB,   1, 0, 0);
    addVec(0, 0, 0, 0, 0, 64'h0,   1, 64'hB,   1, 0, 0);
    addVec(1, 0, 0, 0, 0, 64'h0,   0, 64'h0,   0, 0, 0);
    addVec(0, 1, 0, 0, 0, 64'hA,   1, 64'hA,   1, 0, 0);
    addVec(0, 1, 0, 0, 0, 64'hB,   1, 64'hB,   2, 0, 0);
    addVec(0, 0, 0, 1, 0, 64'h0,   1, 64'hB,   2, 0, 0);
    addVec(0, 0, 1, 0, 0, 64'h0,   1, 64'hA,   1, 0, 0);
    addVec(0, 1, 0, 0, 0, 64'hC,   1, 64'hC,   2, 0, 0);
    addVec(0, 1, 0, 0, 0, 64'hD,   1, 64'hD,   3, 0, 0);
    addVec(0, 0, 0, 0, 1, 64'h0,   1, 64'hB,   2, 0, 0);
    addVec(0, 0, 1, 0, 0, 64'h0,   1, 64'hA,   1, 0, 0);
    addVec(0, 0, 0, 0, 1, 64'h0,   1, 64'hB,   2, 0, 0);
    addVec(1, 0, 0, 0, 1, 64'h0,   0, 64'h0,   0, 0, 0);
    addVec(0, 0, 0, 0, 1, 64'h0,   0, 64'h0,   0, 0, 0);
    addVec(0, 1, 0, 0, 0, 64'h55,  1, 64'h55,  1, 0, 0);
    addVec(0, 1, 0, 1, 0, 64'h66,  1, 64'h66,  2, 0, 0);
    addVec(0, 1, 0, 0, 0, 64'h77,  1, 64'h77,  3, 0, 0);
    addVec(0, 0, 0, 0, 1, 64'h0,   1, 64'h55,  1, 0, 0);

    #3;
    check8("reset", 1'b0, 64'h0, 4'd0, 1'b0, 1'b0);
    #9;
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].flush, vecs[i].push, vecs[i].pop,
                    vecs[i].ckpt, vecs[i].restore, vecs[i].addr);
      check8($sformatf("v%0d", i), vecs[i].exp_valid, vecs[i].exp_top,
             vecs[i].exp_cnt, vecs[i].exp_ovf, vecs[i].exp_udf);
    end

    // Full-stack behaviour on the depth-4 instances.
    doReset();
    pushes = '{64'h10, 64'h20, 64'h30, 64'h40, 64'h50};
    exp_o  = '{64'h50, 64'h40, 64'h30, 64'h20};
    exp_d  = '{64'h40, 64'h30, 64'h20, 64'h10};
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, pushes[i]);
      checkOutput($sformatf("ow.push%0d.ovf", i), {63'b0, ovf4o}, {63'b0, (i == 4)});
      checkOutput($sformatf("dr.push%0d.ovf", i), {63'b0, ovf4d}, {63'b0, (i == 4)});
    end
    checkOutput("ow.full.cnt", {61'b0, cnt4o}, 64'd4);
    checkOutput("dr.full.cnt", {61'b0, cnt4d}, 64'd4);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
    checkOutput("ow.ovf.drop", {63'b0, ovf4o}, 64'd0);
    checkOutput("dr.ovf.drop", {63'b0, ovf4d}, 64'd0);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("ow.pop%0d.top", i), top4o, exp_o[i]);
      checkOutput($sformatf("dr.pop%0d.top", i), top4d, exp_d[i]);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 64'h0);
    end
    checkOutput("ow.empty.valid", {63'b0, valid4o}, 64'd0);
    checkOutput("dr.empty.valid", {63'b0, valid4d}, 64'd0);
    checkOutput("ow.empty.top", top4o, 64'd0);
    checkOutput("dr.empty.cnt", {61'b0, cnt4d}, 64'd0);

    // Asynchronous reset in the middle of a cycle.
    doReset();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 64'h1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 64'h2);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 64'h3);
    check8("prerst", 1'b1, 64'h3, 4'd3, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check8("asyncrst", 1'b0, 64'h0, 4'd0, 1'b0, 1'b0);
    #2;
    rst_n = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 64'h0);
    check8("rst.restore", 1'b0, 64'h0, 4'd0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
